// File: rtl/seg7_reader.sv
// ---------------------------------------------------------------------------
// seg7_reader
//
// Receive-side monitor for a multiplexed, active-low seven-segment display
// bus.  Each (anode, segment) pair must hold for SETTLE_CYCLES consecutive
// clock edges before it is sampled.  A sample decodes the glyph back into a
// hex nibble and stores it in the slot of the selected digit.  Once every
// digit has been sampled, a one-cycle frame strobe is issued.
//
// Ports
//   clk_i          : system clock
//   rst_i          : synchronous, active-high reset
//   an_i[3:0]      : active-low digit anodes (bit n low selects digit n)
//   seg_i[6:0]     : active-low segments, bit 0 = A ... bit 6 = G
//   value_o[15:0]  : decoded digits, digit n at bits [4n+3:4n]
//   digit_valid_o  : bit n set when digit n's last sample decoded legally
//   frame_valid_o  : AND of all digit_valid_o bits
//   frame_strobe_o : one-cycle pulse when all four digits have been sampled
//   err_o          : one-cycle pulse on a sample with an illegal glyph
// ---------------------------------------------------------------------------
module seg7_reader #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] value_o,
    output logic [3:0]  digit_valid_o,
    output logic        frame_valid_o,
    output logic        frame_strobe_o,
    output logic        err_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        SAMPLED
    } state_t;

    state_t       state;
    logic [3:0]   prev_an;
    logic [6:0]   prev_seg;
    logic [CW-1:0] cnt;
    logic [3:0]   seen;

    logic         pair_changed;
    logic         an_legal;
    logic [1:0]   digit_idx;
    logic         seg_legal;
    logic [3:0]   seg_nibble;
    logic         settle_done;
    logic         do_sample;
    logic [3:0]   seen_merge;
    logic [15:0]  value_next;
    logic [3:0]   valid_next;

    // Glyph-to-nibble lookup; bit 4 of the result flags a legal glyph.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return {1'b0, 4'h0};
        endcase
    endfunction

    // A legal anode has exactly one low bit; blank and multi-select are not.
    always_comb begin
        an_legal  = 1'b0;
        digit_idx = 2'd0;
        case (an_i)
            4'b1110: begin an_legal = 1'b1; digit_idx = 2'd0; end
            4'b1101: begin an_legal = 1'b1; digit_idx = 2'd1; end
            4'b1011: begin an_legal = 1'b1; digit_idx = 2'd2; end
            4'b0111: begin an_legal = 1'b1; digit_idx = 2'd3; end
            default: begin an_legal = 1'b0; digit_idx = 2'd0; end
        endcase
    end

    // Decide whether this edge takes a sample, and what the sample produces.
    // With SETTLE_CYCLES == 1 the capture edge is also the sample edge.
    always_comb begin
        pair_changed = (an_i != prev_an) || (seg_i != prev_seg);
        {seg_legal, seg_nibble} = decode_glyph(seg_i);
        settle_done = (cnt == CW'(SETTLE_CYCLES - 1));

        do_sample = 1'b0;
        if (pair_changed)
            do_sample = an_legal && (SETTLE_CYCLES == 1);
        else if (state == SETTLING)
            do_sample = settle_done;

        seen_merge = seen | (4'b0001 << digit_idx);

        value_next = value_o;
        valid_next = digit_valid_o;
        if (seg_legal)
            value_next[{digit_idx, 2'b00} +: 4] = seg_nibble;
        valid_next[digit_idx] = seg_legal;
    end

    // Single state machine: tracks the current dwell, and on a sample updates
    // the registered outputs and frame bookkeeping.  Pulses default low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            prev_an        <= 4'b1111;
            prev_seg       <= 7'h7F;
            cnt            <= '0;
            seen           <= 4'b0000;
            value_o        <= 16'h0000;
            digit_valid_o  <= 4'b0000;
            frame_valid_o  <= 1'b0;
            frame_strobe_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            frame_strobe_o <= 1'b0;
            err_o          <= 1'b0;

            if (pair_changed) begin
                prev_an  <= an_i;
                prev_seg <= seg_i;
                if (an_legal) begin
                    cnt   <= CW'(1);
                    state <= do_sample ? SAMPLED : SETTLING;
                end else begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            end else if (state == SETTLING) begin
                cnt <= cnt + 1'b1;
                if (do_sample)
                    state <= SAMPLED;
            end

            if (do_sample) begin
                value_o       <= value_next;
                digit_valid_o <= valid_next;
                frame_valid_o <= &valid_next;
                err_o         <= ~seg_legal;
                if (&seen_merge) begin
                    frame_strobe_o <= 1'b1;
                    seen           <= 4'b0000;
                end else begin
                    seen <= seen_merge;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_reader
//
// Self-checking bench for seg7_reader (SETTLE_CYCLES = 4).  A behavioural
// model tracks how many consecutive edges the current (anode, segment) pair
// has been held; a pair with a legal anode is sampled on exactly the edge its
// run length reaches SETTLE_CYCLES.  Every output is compared each cycle,
// followed by directed scenarios and a randomized dwell sequence.
// ---------------------------------------------------------------------------
module tb_seg7_reader;

    localparam int SETTLE = 4;

    logic        clk_i;
    logic        rst_i;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic [15:0] value_o;
    logic [3:0]  digit_valid_o;
    logic        frame_valid_o;
    logic        frame_strobe_o;
    logic        err_o;

    int tests_run = 0;
    int tests_failed = 0;
    int strobe_count;

    // Behavioural model state
    logic [3:0]  m_last_an;
    logic [6:0]  m_last_seg;
    int          m_run;
    logic [3:0]  m_seen;
    logic [15:0] m_value;
    logic [3:0]  m_valid;
    logic        m_strobe;
    logic        m_err;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .an_i           (an_i),
        .seg_i          (seg_i),
        .value_o        (value_o),
        .digit_valid_o  (digit_valid_o),
        .frame_valid_o  (frame_valid_o),
        .frame_strobe_o (frame_strobe_o),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock edge of the reference model, fed with the values the DUT saw.
    task automatic modelStep(input logic rst, input logic [3:0] an, input logic [6:0] seg);
        int n;
        int found;
        m_strobe = 1'b0;
        m_err    = 1'b0;
        if (rst) begin
            m_last_an  = 4'b1111;
            m_last_seg = 7'h7F;
            m_run      = 0;
            m_seen     = 4'b0000;
            m_value    = 16'h0000;
            m_valid    = 4'b0000;
        end else begin
            if (an != m_last_an || seg != m_last_seg) begin
                m_last_an  = an;
                m_last_seg = seg;
                m_run      = 1;
            end else if (m_run < 1000) begin
                m_run++;
            end
            if ($countones(~an) == 1 && m_run == SETTLE) begin
                n = 0;
                for (int i = 0; i < 4; i++)
                    if (!an[i]) n = i;
                found = -1;
                for (int g = 0; g < 16; g++)
                    if (glyph[g] == seg) found = g;
                if (found >= 0) begin
                    m_value[n*4 +: 4] = 4'(found);
                    m_valid[n] = 1'b1;
                end else begin
                    m_valid[n] = 1'b0;
                    m_err = 1'b1;
                end
                m_seen[n] = 1'b1;
                if (m_seen == 4'b1111) begin
                    m_strobe = 1'b1;
                    m_seen   = 4'b0000;
                end
            end
        end
    endtask

    // Drive a pair for a number of cycles; check all outputs after each edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] an,
                                 input logic [6:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            rst_i = rst;
            an_i  = an;
            seg_i = seg;
            @(posedge clk_i);
            modelStep(rst, an, seg);
            #1;
            checkOutput("value", 32'(value_o), 32'(m_value));
            checkOutput("digit_valid", 32'(digit_valid_o), 32'(m_valid));
            checkOutput("frame_valid", 32'(frame_valid_o), 32'(&m_valid));
            checkOutput("frame_strobe", 32'(frame_strobe_o), 32'(m_strobe));
            checkOutput("err", 32'(err_o), 32'(m_err));
            if (frame_strobe_o) strobe_count++;
        end
    endtask

    initial begin
        logic [3:0] r_an;
        logic [6:0] r_seg;
        int         pick;

        rst_i = 1'b1;
        an_i  = 4'b1111;
        seg_i = 7'h7F;

        // Reset state
        applyStimulus(1'b1, 4'b1111, 7'h7F, 2);
        checkOutput("reset_value", 32'(value_o), 32'h0);
        checkOutput("reset_valid", 32'(digit_valid_o), 32'h0);

        // Single digit, explicit latency check: sample at capture edge + 3
        applyStimulus(1'b0, 4'b1110, 7'h24, 3);
        checkOutput("lat_before", 32'(digit_valid_o), 32'h0);
        applyStimulus(1'b0, 4'b1110, 7'h24, 1);
        checkOutput("lat_value", 32'(value_o[3:0]), 32'h2);
        checkOutput("lat_valid", 32'(digit_valid_o), 32'h1);
        applyStimulus(1'b0, 4'b1110, 7'h24, 6);

        // Full frame scan
        strobe_count = 0;
        applyStimulus(1'b0, 4'b1110, 7'h19, 6);
        applyStimulus(1'b0, 4'b1101, 7'h00, 6);
        applyStimulus(1'b0, 4'b1011, 7'h46, 6);
        applyStimulus(1'b0, 4'b0111, 7'h0E, 6);
        checkOutput("scan_value", 32'(value_o), 32'hFC84);
        checkOutput("scan_frame_valid", 32'(frame_valid_o), 32'h1);
        checkOutput("scan_strobes", 32'(strobe_count), 32'h1);

        // Illegal glyph on digit 1
        applyStimulus(1'b0, 4'b1101, 7'h7F, 6);
        checkOutput("illegal_valid", 32'(digit_valid_o), 32'hD);
        checkOutput("illegal_value", 32'(value_o), 32'hFC84);

        // Glitch: first pattern held only 2 cycles
        applyStimulus(1'b0, 4'b1110, 7'h24, 2);
        applyStimulus(1'b0, 4'b1110, 7'h30, 6);
        checkOutput("glitch_value", 32'(value_o[3:0]), 32'h3);

        // Illegal anode, then blank
        applyStimulus(1'b0, 4'b1100, 7'h40, 20);
        applyStimulus(1'b0, 4'b1111, 7'h40, 20);
        checkOutput("blank_value", 32'(value_o), 32'hFC83);

        // Reset mid-settle, then keep holding the same pair
        applyStimulus(1'b0, 4'b1011, 7'h79, 2);
        applyStimulus(1'b1, 4'b1011, 7'h79, 1);
        checkOutput("midrst_value", 32'(value_o), 32'h0);
        applyStimulus(1'b0, 4'b1011, 7'h79, 6);

        // Randomized dwells
        for (int d = 0; d < 300; d++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70)      r_an = ~(4'b0001 << $urandom_range(0, 3));
            else if (pick < 85) r_an = 4'b1111;
            else                r_an = 4'($urandom);
            if ($urandom_range(0, 99) < 80) r_seg = glyph[$urandom_range(0, 15)];
            else                            r_seg = 7'($urandom);
            applyStimulus($urandom_range(0, 99) < 2, r_an, r_seg, $urandom_range(1, 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
